// File: rtl/osc_pkg.sv
// ---------------------------------------------------------------------------
// osc_pkg
// Shared definitions for the sine-oscillator control sequencer:
//   - default widths for the sample-rate divider and the sample counter
//   - Q2.29 fixed-point constants used by the oscillator datapath
//   - sequencer state encoding (IDLE / LOAD / RUN)
//   - helper turning a divider word into its down-counter reload value
// Optional feature macro used by the files that import this package:
//   OSC_BURST_EN  (burst length / done support)
// ---------------------------------------------------------------------------
package osc_pkg;

    localparam int DIV_W_DEF = 16;
    localparam int CNT_W_DEF = 24;

    // Q2.29: 1.0 is 2^29
    localparam logic [31:0] Q_ONE  = 32'h2000_0000;
    localparam int          Q_FRAC = 29;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // A divider word of 0 paces like 1, so both reload the counter with 0.
    function automatic logic [31:0] div_reload(input logic [31:0] div);
        return (div == 32'd0) ? 32'd0 : div - 32'd1;
    endfunction

endpackage

// File: rtl/osc_sequencer_if.sv
// ---------------------------------------------------------------------------
// osc_sequencer_if
// Tone-configuration channel between host/register side and the sequencer.
//   cfg_valid  host -> seq   config request
//   cfg_ready  seq  -> host  config accept (transfer on cfg_valid & cfg_ready)
//   cfg_init1  host -> seq   seed sin(w), Q2.29
//   cfg_init2  host -> seq   coefficient 2cos(w), Q2.29
//   cfg_div    host -> seq   clock cycles per oscillator step (0 acts as 1)
//   cfg_count  host -> seq   burst length, only when OSC_BURST_EN is defined
// Modports: master (host side), slave (sequencer side).
// ---------------------------------------------------------------------------
interface osc_sequencer_if #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 24
);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [31:0]      cfg_init1;
    logic [31:0]      cfg_init2;
    logic [DIV_W-1:0] cfg_div;
`ifdef OSC_BURST_EN
    logic [CNT_W-1:0] cfg_count;
`endif

    modport master (
        output cfg_valid, cfg_init1, cfg_init2, cfg_div,
`ifdef OSC_BURST_EN
        output cfg_count,
`endif
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_init1, cfg_init2, cfg_div,
`ifdef OSC_BURST_EN
        input  cfg_count,
`endif
        output cfg_ready
    );

endinterface

// File: rtl/osc_tick_div.sv
// ---------------------------------------------------------------------------
// osc_tick_div
// Loadable down-counter pacing oscillator steps. tick is high while the
// count is 0; when running, a 0 count reloads, otherwise it decrements.
// Ports:
//   Fg_CLK      in  clock
//   RESETn      in  asynchronous active-low reset
//   load        in  force the count to reload_val
//   run         in  count this cycle
//   reload_val  in  W-bit reload value (cycles per tick minus one)
//   tick        out count is zero
// ---------------------------------------------------------------------------
module osc_tick_div #(
    parameter int W = 16
) (
    input  logic         Fg_CLK,
    input  logic         RESETn,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] reload_val,
    output logic         tick
);

    logic [W-1:0] cnt;

    assign tick = (cnt == '0);

    // Reload on the explicit load, otherwise count down and wrap to the
    // reload value each time a tick is produced.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= reload_val;
        end else if (run) begin
            cnt <= tick ? reload_val : cnt - W'(1);
        end
    end

endmodule

// File: rtl/osc_sequencer.sv
// ---------------------------------------------------------------------------
// osc_sequencer
// Control sequencer for the recursive sine oscillator
// (y[n] = 2cos(w)*y[n-1] - y[n-2]). Accepts a tone configuration, seeds the
// oscillator with a one-cycle Ready pulse, then paces Enable steps with a
// programmable divider and flags each new sample.
// Optional feature: define OSC_BURST_EN to add cfg_count/done (fixed-length
// bursts); without it the sequencer runs until stop or a retune.
// Ports:
//   Fg_CLK         in   clock, posedge
//   RESETn         in   asynchronous active-low reset
//   cfg            if   osc_sequencer_if.slave configuration channel
//   stop           in   abort the run (only acts in RUN)
//   Ready          out  oscillator seed strobe (LOAD cycle)
//   Enable         out  oscillator step strobe
//   init1/init2    out  captured seed / coefficient
//   sample_strobe  out  Enable delayed by one cycle
//   sample_cnt     out  Enables since the last LOAD, wraps
//   busy           out  not idle
//   done           out  burst finished (OSC_BURST_EN only)
// ---------------------------------------------------------------------------
module osc_sequencer
    import osc_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                Fg_CLK,
    input  logic                RESETn,
    osc_sequencer_if.slave      cfg,
    input  logic                stop,
    output logic                Ready,
    output logic                Enable,
    output logic [31:0]         init1,
    output logic [31:0]         init2,
    output logic                sample_strobe,
    output logic [CNT_W-1:0]    sample_cnt,
`ifdef OSC_BURST_EN
    output logic                done,
`endif
    output logic                busy
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] div_m1;
    logic             tick;
    logic             xfer;
    logic             last;

    // stop in RUN blocks the handshake, so stop always wins over a retune.
    assign cfg.cfg_ready = (state == ST_IDLE) | ((state == ST_RUN) & ~stop);
    assign xfer          = cfg.cfg_valid & cfg.cfg_ready;
    assign Ready         = (state == ST_LOAD);
    assign Enable        = (state == ST_RUN) & tick & ~stop;
    assign busy          = (state != ST_IDLE);

`ifdef OSC_BURST_EN
    logic [CNT_W-1:0] count_reg;
    assign last = (sample_cnt == count_reg - CNT_W'(1));
`else
    assign last = 1'b0;
`endif

    osc_tick_div #(.W(DIV_W)) u_tick_div (
        .Fg_CLK     (Fg_CLK),
        .RESETn     (RESETn),
        .load       (state == ST_LOAD),
        .run        (state == ST_RUN),
        .reload_val (div_m1),
        .tick       (tick)
    );

    // Next-state selection; a retune in RUN goes back through LOAD so the
    // oscillator phase restarts from the new seed.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer) state_nxt = ST_LOAD;
`ifdef OSC_BURST_EN
            ST_LOAD: state_nxt = (count_reg == '0) ? ST_IDLE : ST_RUN;
`else
            ST_LOAD: state_nxt = ST_RUN;
`endif
            ST_RUN: begin
                if (stop)               state_nxt = ST_IDLE;
                else if (xfer)          state_nxt = ST_LOAD;
                else if (Enable & last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register, configuration capture and sample bookkeeping.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state         <= ST_IDLE;
            init1         <= '0;
            init2         <= '0;
            div_m1        <= '0;
            sample_strobe <= 1'b0;
            sample_cnt    <= '0;
        end else begin
            state         <= state_nxt;
            sample_strobe <= Enable;
            if (xfer) begin
                init1  <= cfg.cfg_init1;
                init2  <= cfg.cfg_init2;
                div_m1 <= DIV_W'(div_reload(32'(cfg.cfg_div)));
            end
            if (state == ST_LOAD) begin
                sample_cnt <= '0;
            end else if (Enable) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
            end
        end
    end

`ifdef OSC_BURST_EN
    // done lines up with the sample_strobe of the final sample; a zero-length
    // burst reports done straight after LOAD. A retune in the final cycle
    // abandons the burst silently.
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            count_reg <= '0;
            done      <= 1'b0;
        end else begin
            if (xfer) begin
                count_reg <= cfg.cfg_count;
            end
            done <= ((state == ST_LOAD) & (count_reg == '0)) | (Enable & last & ~xfer);
        end
    end
`endif

endmodule

// File: tb/tb_osc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_osc_sequencer
// Self-checking bench for osc_sequencer: directed per-cycle vector table,
// hand-written reset/retune/burst sequences, then randomized traffic checked
// against a cycle-level reference model derived from the behavioural rules.
// Honours OSC_BURST_EN to match the build of the design.
// ---------------------------------------------------------------------------
module tb_osc_sequencer;

    localparam int DIV_W = 16;
    localparam int CNT_W = 24;
`ifdef OSC_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam logic [31:0] SEED = 32'h0B50_4F33;
    localparam logic [31:0] COEF = 32'h2D41_3CCD;

    logic             Fg_CLK = 1'b0;
    logic             RESETn = 1'b0;
    logic             stop   = 1'b0;
    logic             Ready;
    logic             Enable;
    logic [31:0]      init1;
    logic [31:0]      init2;
    logic             sample_strobe;
    logic [CNT_W-1:0] sample_cnt;
    logic             busy;
    logic             done_w;

    int errors = 0;
    int checks = 0;

    osc_sequencer_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) cfg_bus ();

    osc_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .Fg_CLK        (Fg_CLK),
        .RESETn        (RESETn),
        .cfg           (cfg_bus),
        .stop          (stop),
        .Ready         (Ready),
        .Enable        (Enable),
        .init1         (init1),
        .init2         (init2),
        .sample_strobe (sample_strobe),
        .sample_cnt    (sample_cnt),
`ifdef OSC_BURST_EN
        .done          (done_w),
`endif
        .busy          (busy)
    );

`ifndef OSC_BURST_EN
    assign done_w = 1'b0;
`endif

    always #5 Fg_CLK = ~Fg_CLK;

    // one directed cycle: inputs plus expected observable outputs
    typedef struct {
        logic             valid;
        logic             stp;
        logic [DIV_W-1:0] div;
        logic             exp_ready;
        logic             exp_enable;
        logic             exp_cfg_ready;
        logic             exp_busy;
        logic             exp_strobe;
        int               exp_cnt;
    } vec_t;

    vec_t vecs[20];

    // reference model state
    int               m_mode;   // 0 idle, 1 seeding, 2 stepping
    int               m_k;      // cycles spent stepping since the seed
    int               m_div;
    logic [31:0]      m_i1, m_i2;
    logic [CNT_W-1:0] m_cnt, m_count;
    logic             m_strobe, m_done;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive inputs on the falling edge, leave 1 time unit for outputs to settle
    task automatic apply_stimulus(input logic v, input logic s, input logic [DIV_W-1:0] d,
                                  input logic [31:0] i1, input logic [31:0] i2,
                                  input logic [CNT_W-1:0] c);
        @(negedge Fg_CLK);
        cfg_bus.cfg_valid = v;
        stop              = s;
        cfg_bus.cfg_div   = d;
        cfg_bus.cfg_init1 = i1;
        cfg_bus.cfg_init2 = i2;
`ifdef OSC_BURST_EN
        cfg_bus.cfg_count = c;
`else
        if (c != '0) begin end
`endif
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, ".Ready"},  32'(Ready), 32'd0);
        check_output({tag, ".Enable"}, 32'(Enable), 32'd0);
        check_output({tag, ".init1"},  init1, 32'd0);
        check_output({tag, ".init2"},  init2, 32'd0);
        check_output({tag, ".strobe"}, 32'(sample_strobe), 32'd0);
        check_output({tag, ".cnt"},    32'(sample_cnt), 32'd0);
        check_output({tag, ".busy"},   32'(busy), 32'd0);
        if (BURST) check_output({tag, ".done"}, 32'(done_w), 32'd0);
    endtask

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_div = 1;
        m_i1 = '0; m_i2 = '0; m_cnt = '0; m_count = '0;
        m_strobe = 1'b0; m_done = 1'b0;
    endtask

    // compare DUT against the model for the current cycle, then advance the
    // model across the coming rising edge
    task automatic model_step(input logic v, input logic s, input logic [DIV_W-1:0] d,
                              input logic [31:0] i1, input logic [31:0] i2,
                              input logic [CNT_W-1:0] c);
        logic exp_en, exp_cr, xfer, last_hit;
        exp_en = (m_mode == 2) && !s && ((m_k % m_div) == 0);
        exp_cr = (m_mode == 0) || ((m_mode == 2) && !s);
        xfer   = v && exp_cr;
        check_output("rnd.Ready",     32'(Ready), 32'(m_mode == 1));
        check_output("rnd.Enable",    32'(Enable), 32'(exp_en));
        check_output("rnd.cfg_ready", 32'(cfg_bus.cfg_ready), 32'(exp_cr));
        check_output("rnd.busy",      32'(busy), 32'(m_mode != 0));
        check_output("rnd.init1",     init1, m_i1);
        check_output("rnd.init2",     init2, m_i2);
        check_output("rnd.strobe",    32'(sample_strobe), 32'(m_strobe));
        check_output("rnd.cnt",       32'(sample_cnt), 32'(m_cnt));
        if (BURST) check_output("rnd.done", 32'(done_w), 32'(m_done));

        last_hit = BURST && exp_en && (m_cnt + CNT_W'(1) == m_count);
        m_done   = BURST && (((m_mode == 1) && (m_count == '0)) || (last_hit && !xfer));
        m_strobe = exp_en;
        if (m_mode == 1)  m_cnt = '0;
        else if (exp_en)  m_cnt = m_cnt + CNT_W'(1);
        if (xfer) begin
            m_mode = 1; m_i1 = i1; m_i2 = i2; m_count = c;
            m_div  = (d == '0) ? 1 : int'(d);
        end else if (m_mode == 1) begin
            m_mode = (BURST && m_count == '0) ? 0 : 2;
            m_k    = 1;
        end else if (m_mode == 2) begin
            if (s || last_hit) m_mode = 0;
            else               m_k++;
        end
    endtask

    task automatic do_reset();
        @(negedge Fg_CLK);
        RESETn = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        stop = 1'b0;
        #2;
        @(negedge Fg_CLK);
        RESETn = 1'b1;
        #1;
    endtask

    initial begin
        logic v, s;
        logic [DIV_W-1:0] d;
        logic [31:0] r1, r2;
        logic [CNT_W-1:0] c;
        int n_en, n_done, n_strobe, done_at;

        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = '0;
        cfg_bus.cfg_init1 = '0;
        cfg_bus.cfg_init2 = '0;
`ifdef OSC_BURST_EN
        cfg_bus.cfg_count = '0;
`endif

        // div=4 run, stop+valid collision, stop ignored in IDLE/LOAD, div=0 run
        //           v     s     div  R     E     cr    busy  strb  cnt
        vecs[0]  = '{1'b1, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 1'b0, 16'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
        vecs[2]  = '{1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[3]  = '{1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[4]  = '{1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0};
        vecs[5]  = '{1'b0, 1'b0, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        vecs[6]  = '{1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1};
        vecs[7]  = '{1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[8]  = '{1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1};
        vecs[9]  = '{1'b0, 1'b0, 16'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b1, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2};
        vecs[11] = '{1'b0, 1'b0, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[12] = '{1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[13] = '{1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        vecs[14] = '{1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[15] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
        vecs[16] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        vecs[17] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2};
        vecs[18] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3};
        vecs[19] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3};

        // outputs during reset
        #12;
        check_all_zero("rst");
        check_output("rst.cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        @(negedge Fg_CLK);
        RESETn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].stp, vecs[i].div, SEED, COEF, 24'd100);
            check_output($sformatf("vec%0d.Ready", i),     32'(Ready), 32'(vecs[i].exp_ready));
            check_output($sformatf("vec%0d.Enable", i),    32'(Enable), 32'(vecs[i].exp_enable));
            check_output($sformatf("vec%0d.cfg_ready", i), 32'(cfg_bus.cfg_ready), 32'(vecs[i].exp_cfg_ready));
            check_output($sformatf("vec%0d.busy", i),      32'(busy), 32'(vecs[i].exp_busy));
            check_output($sformatf("vec%0d.strobe", i),    32'(sample_strobe), 32'(vecs[i].exp_strobe));
            check_output($sformatf("vec%0d.cnt", i),       32'(sample_cnt), 32'(vecs[i].exp_cnt));
            if (i == 1) begin
                check_output("vec1.init1", init1, SEED);
                check_output("vec1.init2", init2, COEF);
            end
        end

        // retune while stepping
        apply_stimulus(1'b1, 1'b0, 16'd2, 32'h1111_1111, 32'h2222_2222, 24'd100);
        apply_stimulus(1'b0, 1'b0, 16'd2, 32'h0, 32'h0, 24'd100);
        apply_stimulus(1'b0, 1'b0, 16'd2, 32'h0, 32'h0, 24'd100);
        apply_stimulus(1'b0, 1'b0, 16'd2, 32'h0, 32'h0, 24'd100);
        check_output("retune.pre_enable", 32'(Enable), 32'd1);
        apply_stimulus(1'b1, 1'b0, 16'd3, 32'h3333_3333, 32'h4444_4444, 24'd100);
        check_output("retune.cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check_output("retune.cnt_before", 32'(sample_cnt), 32'd1);
        check_output("retune.old_init1", init1, 32'h1111_1111);
        apply_stimulus(1'b0, 1'b0, 16'd3, 32'h0, 32'h0, 24'd100);
        check_output("retune.Ready", 32'(Ready), 32'd1);
        check_output("retune.no_overlap", 32'(Enable), 32'd0);
        check_output("retune.init1", init1, 32'h3333_3333);
        check_output("retune.init2", init2, 32'h4444_4444);
        apply_stimulus(1'b0, 1'b0, 16'd3, 32'h0, 32'h0, 24'd100);
        check_output("retune.cnt_cleared", 32'(sample_cnt), 32'd0);
        check_output("retune.Ready_off", 32'(Ready), 32'd0);

        // asynchronous reset while running at div=4
        apply_stimulus(1'b0, 1'b1, 16'd3, 32'h0, 32'h0, 24'd0);
        apply_stimulus(1'b1, 1'b0, 16'd4, 32'h5555_5555, 32'h6666_6666, 24'd100);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b0, 16'd4, 32'h0, 32'h0, 24'd100);
        check_output("arst.pre_busy", 32'(busy), 32'd1);
        check_output("arst.pre_strobe", 32'(sample_strobe), 32'd1);
        RESETn = 1'b0;
        #1;
        check_all_zero("arst");
        @(negedge Fg_CLK);
        RESETn = 1'b1;
        #1;
        check_output("arst.cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
        check_output("arst.busy", 32'(busy), 32'd0);

`ifdef OSC_BURST_EN
        // burst of 5 samples at div=2
        n_en = 0; n_done = 0; n_strobe = 0; done_at = -1;
        apply_stimulus(1'b1, 1'b0, 16'd2, SEED, COEF, 24'd5);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, 1'b0, 16'd2, 32'h0, 32'h0, 24'd0);
            if (Enable) n_en++;
            if (sample_strobe) n_strobe++;
            if (done_w) begin
                n_done++;
                done_at = sample_strobe ? n_strobe : -1;
            end
        end
        check_output("burst5.enables", 32'(n_en), 32'd5);
        check_output("burst5.done_count", 32'(n_done), 32'd1);
        check_output("burst5.done_on_5th", 32'(done_at), 32'd5);
        check_output("burst5.idle", 32'(busy), 32'd0);

        // zero-length burst
        apply_stimulus(1'b1, 1'b0, 16'd2, SEED, COEF, 24'd0);
        apply_stimulus(1'b0, 1'b0, 16'd2, 32'h0, 32'h0, 24'd0);
        check_output("burst0.Ready", 32'(Ready), 32'd1);
        apply_stimulus(1'b0, 1'b0, 16'd2, 32'h0, 32'h0, 24'd0);
        check_output("burst0.done", 32'(done_w), 32'd1);
        check_output("burst0.busy", 32'(busy), 32'd0);
        check_output("burst0.Enable", 32'(Enable), 32'd0);
        apply_stimulus(1'b0, 1'b0, 16'd2, 32'h0, 32'h0, 24'd0);
        check_output("burst0.done_off", 32'(done_w), 32'd0);
        check_output("burst0.cnt", 32'(sample_cnt), 32'd0);
`else
        n_en = 0; n_done = 0; n_strobe = 0; done_at = 0;
        if (n_en + n_done + n_strobe + done_at != 0) $display("[TB] unexpected counter state");
`endif

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 15) == 0);
            d  = DIV_W'($urandom_range(0, 4));
            r1 = $urandom;
            r2 = $urandom;
            c  = CNT_W'($urandom_range(0, 6));
            apply_stimulus(v, s, d, r1, r2, c);
            model_step(v, s, d, r1, r2, c);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
